// File: rtl/jt89_pkg.sv
// jt89_pkg: shared definitions for the JT89 PSG register writer.
//   - Register index constants ({ch[1:0], type}) used by the latch/data decode.
//   - Reset constants for tone periods and attenuations.
//   - Write-handshake FSM state encoding.
// Optional feature macro: JT89_READY_EN (selects whether ST_BUSY is reachable).
package jt89_pkg;

    localparam logic [2:0] IDX_TONE0 = 3'd0;
    localparam logic [2:0] IDX_VOL0  = 3'd1;
    localparam logic [2:0] IDX_TONE1 = 3'd2;
    localparam logic [2:0] IDX_VOL1  = 3'd3;
    localparam logic [2:0] IDX_TONE2 = 3'd4;
    localparam logic [2:0] IDX_VOL2  = 3'd5;
    localparam logic [2:0] IDX_NOISE = 3'd6;
    localparam logic [2:0] IDX_VOL3  = 3'd7;

    localparam logic [3:0] VOL_OFF  = 4'hF;
    localparam logic [9:0] TONE_RST = 10'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_REL  = 2'd2
    } wr_state_e;

endpackage

// File: rtl/jt89_wrsync.sv
// jt89_wrsync: brings the asynchronous CPU write strobe into the clk domain.
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset (chain resets to 1 = released)
//   cs_n      in   chip select, active low, asynchronous
//   wr_n      in   write strobe, active low, asynchronous
//   we_ev     out  one-cycle write event: synchronised strobe just went low
//   strobe_hi out  synchronised strobe level (s2), high = released
module jt89_wrsync (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_n,
    input  logic wr_n,
    output logic we_ev,
    output logic strobe_hi
);

    // sync_q[0] = s1, sync_q[1] = s2, sync_q[2] = s3
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[1:0], cs_n | wr_n};
        end
    end

    assign we_ev     = ~sync_q[1] & sync_q[2];
    assign strobe_hi = sync_q[1];

endmodule

// File: rtl/jt89_regs.sv
// jt89_regs: CPU-side register writer/decoder for the JT89 PSG.
// Decodes SN76489-style latch/data bytes into tone periods, attenuations and
// the noise control word, pulses clr on noise writes and models READY.
//   clk, rst_n          clock, asynchronous active-low reset
//   clken               chip clock enable (paces the READY busy count)
//   din[7:0]            CPU data bus
//   cs_n, wr_n          active-low asynchronous write strobes
//   ready               high = a write can be accepted
//   tone0..tone2[9:0]   tone period registers
//   vol0..vol3[3:0]     attenuations (vol3 = noise), reset to off
//   ctrl3[2:0]          noise control {fb, rate[1:0]}
//   clr                 one-clk pulse that clears the noise LFSR
// Optional feature macro: JT89_READY_EN -- when defined, READY drops for
// BUSY_CYCLES clken pulses after each accepted write and writes arriving in
// that window are ignored; otherwise READY is tied high.
module jt89_regs
`ifdef JT89_READY_EN
#(
    parameter int unsigned BUSY_CYCLES = 32
)
`endif
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clken,
    input  logic [7:0] din,
    input  logic       cs_n,
    input  logic       wr_n,
    output logic       ready,
    output logic [9:0] tone0,
    output logic [9:0] tone1,
    output logic [9:0] tone2,
    output logic [3:0] vol0,
    output logic [3:0] vol1,
    output logic [3:0] vol2,
    output logic [3:0] vol3,
    output logic [2:0] ctrl3,
    output logic       clr
);

    import jt89_pkg::*;

    logic       we_ev;
    logic       strobe_hi;

    jt89_wrsync u_wrsync (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs_n      (cs_n),
        .wr_n      (wr_n),
        .we_ev     (we_ev),
        .strobe_hi (strobe_hi)
    );

    wr_state_e  state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [9:0] tone0_q, tone0_d, tone1_q, tone1_d, tone2_q, tone2_d;
    logic [3:0] vol0_q, vol0_d, vol1_q, vol1_d, vol2_q, vol2_d, vol3_q, vol3_d;
    logic [2:0] ctrl3_q, ctrl3_d;
    logic       clr_q, clr_d;
    logic       do_wr;
    logic [2:0] sel;

`ifdef JT89_READY_EN
    logic [7:0] cnt_q, cnt_d;
`else
    logic       unused_clken;
    assign unused_clken = clken;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tone0_d = tone0_q;
        tone1_d = tone1_q;
        tone2_d = tone2_q;
        vol0_d  = vol0_q;
        vol1_d  = vol1_q;
        vol2_d  = vol2_q;
        vol3_d  = vol3_q;
        ctrl3_d = ctrl3_q;
        clr_d   = 1'b0;
        do_wr   = 1'b0;
`ifdef JT89_READY_EN
        cnt_d   = cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (we_ev) begin
                    do_wr = 1'b1;
`ifdef JT89_READY_EN
                    state_d = ST_BUSY;
                    cnt_d   = 8'(BUSY_CYCLES - 1);
`else
                    state_d = ST_REL;
`endif
                end
            end
`ifdef JT89_READY_EN
            ST_BUSY: begin
                if (clken) begin
                    if (cnt_q == '0) begin
                        state_d = ST_REL;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
`endif
            ST_REL: begin
                // A strobe still held low must be released before re-arming.
                if (strobe_hi) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Latch bytes carry their own index; data bytes use the latched one.
        sel = din[7] ? din[6:4] : idx_q;

        if (do_wr) begin
            if (din[7]) begin
                idx_d = din[6:4];
            end
            unique case (sel)
                IDX_TONE0: tone0_d = din[7] ? {tone0_q[9:4], din[3:0]} : {din[5:0], tone0_q[3:0]};
                IDX_TONE1: tone1_d = din[7] ? {tone1_q[9:4], din[3:0]} : {din[5:0], tone1_q[3:0]};
                IDX_TONE2: tone2_d = din[7] ? {tone2_q[9:4], din[3:0]} : {din[5:0], tone2_q[3:0]};
                IDX_VOL0:  vol0_d  = din[3:0];
                IDX_VOL1:  vol1_d  = din[3:0];
                IDX_VOL2:  vol2_d  = din[3:0];
                IDX_VOL3:  vol3_d  = din[3:0];
                IDX_NOISE: begin
                    ctrl3_d = din[2:0];
                    clr_d   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= IDX_TONE0;
            tone0_q <= TONE_RST;
            tone1_q <= TONE_RST;
            tone2_q <= TONE_RST;
            vol0_q  <= VOL_OFF;
            vol1_q  <= VOL_OFF;
            vol2_q  <= VOL_OFF;
            vol3_q  <= VOL_OFF;
            ctrl3_q <= '0;
            clr_q   <= 1'b0;
`ifdef JT89_READY_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tone0_q <= tone0_d;
            tone1_q <= tone1_d;
            tone2_q <= tone2_d;
            vol0_q  <= vol0_d;
            vol1_q  <= vol1_d;
            vol2_q  <= vol2_d;
            vol3_q  <= vol3_d;
            ctrl3_q <= ctrl3_d;
            clr_q   <= clr_d;
`ifdef JT89_READY_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

`ifdef JT89_READY_EN
    assign ready = (state_q != ST_BUSY);
`else
    assign ready = 1'b1;
`endif

    assign tone0 = tone0_q;
    assign tone1 = tone1_q;
    assign tone2 = tone2_q;
    assign vol0  = vol0_q;
    assign vol1  = vol1_q;
    assign vol2  = vol2_q;
    assign vol3  = vol3_q;
    assign ctrl3 = ctrl3_q;
    assign clr   = clr_q;

endmodule

// File: tb/tb_jt89_regs.sv
// tb_jt89_regs: directed self-checking bench for jt89_regs.
// Covers both builds; the READY/BUSY sequences compile in with JT89_READY_EN.
module tb_jt89_regs;

    logic       clk;
    logic       rst_n;
    logic       clken;
    logic [7:0] din;
    logic       cs_n;
    logic       wr_n;
    logic       ready;
    logic [9:0] tone0, tone1, tone2;
    logic [3:0] vol0, vol1, vol2, vol3;
    logic [2:0] ctrl3;
    logic       clr;

    int checks = 0;
    int errors = 0;
    int clr_seen = 0;
    int rdy_low = 0;
    int busy_pulses = 0;
    int ck_div = 0;
    int c0;
    int p0;

    jt89_regs dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clken (clken),
        .din   (din),
        .cs_n  (cs_n),
        .wr_n  (wr_n),
        .ready (ready),
        .tone0 (tone0),
        .tone1 (tone1),
        .tone2 (tone2),
        .vol0  (vol0),
        .vol1  (vol1),
        .vol2  (vol2),
        .vol3  (vol3),
        .ctrl3 (ctrl3),
        .clr   (clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // clken high on every 4th clk, changing away from the active edge
    initial begin
        clken = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            ck_div = ck_div + 1;
            clken  = ((ck_div % 4) == 0);
        end
    end

    // Output monitors sampled on the inactive edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (clr === 1'b1) clr_seen = clr_seen + 1;
                if (ready === 1'b0) rdy_low = rdy_low + 1;
                if (ready === 1'b0 && clken === 1'b1) busy_pulses = busy_pulses + 1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_byte(input logic [7:0] b);
        @(negedge clk);
        din  = b;
        cs_n = 1'b0;
        wr_n = 1'b0;
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        wr_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_rdy();
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 600) begin
            @(negedge clk);
            n = n + 1;
        end
        if (n >= 600) chk("ready_timeout", 16'(ready), 16'h1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wr_full(input logic [7:0] b);
        wr_byte(b);
`ifdef JT89_READY_EN
        wait_rdy();
`endif
    endtask

    initial begin
        rst_n = 1'b1;
        cs_n  = 1'b1;
        wr_n  = 1'b1;
        din   = 8'h00;

        // 1. asynchronous reset with random bus activity
        #3 rst_n = 1'b0;
        #1;
        chk("rst_tone0", 16'(tone0), 16'h000);
        chk("rst_tone1", 16'(tone1), 16'h000);
        chk("rst_tone2", 16'(tone2), 16'h000);
        chk("rst_vol0", 16'(vol0), 16'hF);
        chk("rst_vol1", 16'(vol1), 16'hF);
        chk("rst_vol2", 16'(vol2), 16'hF);
        chk("rst_vol3", 16'(vol3), 16'hF);
        chk("rst_ctrl3", 16'(ctrl3), 16'h0);
        chk("rst_clr", 16'(clr), 16'h0);
        chk("rst_ready", 16'(ready), 16'h1);
        for (int i = 0; i < 12; i++) begin
            #7;
            din  = 8'($urandom);
            cs_n = 1'($urandom);
            wr_n = 1'($urandom);
        end
        chk("rst_hold_vol3", 16'(vol3), 16'hF);
        chk("rst_hold_tone0", 16'(tone0), 16'h000);
        cs_n = 1'b1;
        wr_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 2. tone0 latch + data
        c0 = clr_seen;
        wr_full(8'h8E);
        wr_full(8'h0F);
        chk("t2_tone0", 16'(tone0), 16'h0FE);
        chk("t2_tone1", 16'(tone1), 16'h000);
        chk("t2_tone2", 16'(tone2), 16'h000);
        chk("t2_no_clr", 16'(clr_seen - c0), 16'd0);

        // 3. noise control latch + data, each with a single clr pulse
        c0 = clr_seen;
        wr_full(8'hE5);
        chk("t3_ctrl3_latch", 16'(ctrl3), 16'h5);
        chk("t3_clr_once", 16'(clr_seen - c0), 16'd1);
        wr_full(8'h02);
        chk("t3_ctrl3_data", 16'(ctrl3), 16'h2);
        chk("t3_clr_twice", 16'(clr_seen - c0), 16'd2);

        // 4. vol0 with exact update edge: strobe set, 2 edges -> old, 3rd -> new
        @(negedge clk);
        din  = 8'h9A;
        cs_n = 1'b0;
        wr_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_vol0_edge2", 16'(vol0), 16'hF);
        @(negedge clk);
        chk("t4_vol0_edge3", 16'(vol0), 16'hA);
        @(negedge clk);
        cs_n = 1'b1;
        wr_n = 1'b1;
        repeat (3) @(negedge clk);
`ifdef JT89_READY_EN
        wait_rdy();
`endif
        wr_full(8'h03);
        chk("t4_vol0_data", 16'(vol0), 16'h3);
        chk("t4_tone0_kept", 16'(tone0), 16'h0FE);

        // vol3 (index 7) latch and data
        wr_full(8'hF0);
        chk("vol3_latch", 16'(vol3), 16'h0);
        wr_full(8'h09);
        chk("vol3_data", 16'(vol3), 16'h9);

        wr_full(8'hD7);
        chk("vol2_latch", 16'(vol2), 16'h7);

`ifdef JT89_READY_EN
        // 5. busy window: 32 clken pulses, writes during it ignored
        p0 = busy_pulses;
        c0 = rdy_low;
        wr_byte(8'hC7);
        chk("t5_ready_low", 16'(ready), 16'h0);
        chk("t5_tone2", 16'(tone2), 16'h007);
        wr_byte(8'hDF);
        wait_rdy();
        chk("t5_busy_pulses", 16'(busy_pulses - p0), 16'd32);
        chk("t5_vol2_kept", 16'(vol2), 16'h7);
        // latched index must still be tone2
        wr_full(8'h05);
        chk("t5_idx_kept", 16'(tone2), 16'h057);

        // 6. reset mid-BUSY
        wr_byte(8'hC3);
        chk("t6_tone2_written", 16'(tone2), 16'h053);
        p0 = busy_pulses;
        for (int n = 0; n < 200 && (busy_pulses - p0) < 10; n++) @(negedge clk);
        chk("t6_in_busy", 16'(ready), 16'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_ready_async", 16'(ready), 16'h1);
        chk("t6_tone2_rst", 16'(tone2), 16'h000);
        chk("t6_vol2_rst", 16'(vol2), 16'hF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        wr_byte(8'h85);
        chk("t6_accept_tone0", 16'(tone0), 16'h005);
        chk("t6_accept_busy", 16'(ready), 16'h0);
        wait_rdy();
`else
        // feature off: no busy window, back-to-back writes all land
        wr_full(8'hC7);
        chk("nb_tone2", 16'(tone2), 16'h007);
        wr_full(8'hDF);
        chk("nb_vol2_taken", 16'(vol2), 16'hF);
        wr_full(8'h05);
        chk("nb_vol2_data", 16'(vol2), 16'h5);
        chk("nb_tone2_kept", 16'(tone2), 16'h007);
        chk("nb_ready_never_low", 16'(rdy_low), 16'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jt89_regs.md
Name: jt89_regs

Overview:
- CPU-side register writer/decoder for the JT89 PSG.
- Accepts SN76489-style byte writes on an 8-bit bus with active-low strobes.
- Decodes latch/data bytes into the three tone periods, four attenuations and the noise control word.
- Drives the tone and noise channel blocks, including the noise-shift clear pulse. Models the chip READY handshake.

Parameters:
- BUSY_CYCLES, 32, number of clken pulses READY stays low after an accepted write (only with JT89_READY_EN); legal range 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- clken  in  1  chip clock enable (same enable the channel blocks use)
- din  in  8  CPU data bus; must be stable while the strobe is low
- cs_n  in  1  chip select, active low, asynchronous to clk
- wr_n  in  1  write strobe, active low, asynchronous to clk
- ready  out  1  high = chip can accept a write
- tone0, tone1, tone2  out  10 each  tone period registers
- vol0, vol1, vol2, vol3  out  4 each  attenuation (0 = loudest, 15 = off); vol3 is noise
- ctrl3  out  3  noise control {fb, rate[1:0]}
- clr  out  1  one-clk pulse that resets the noise LFSR

Behaviour:
- Reset (async, immediate): tone* = 0, vol* = 4'hF, ctrl3 = 0, clr = 0, ready = 1, latched index = 0 (tone0), FSM = IDLE, synchronisers = 1.
- Strobe s = cs_n | wr_n is passed through a 3-flop chain s1 → s2 → s3. A write event fires on the clk edge where s2 = 0 and s3 = 1.
- din is sampled on the event cycle.
- Register outputs update on the next clk edge, i.e. the 3rd rising clk edge after the first edge that samples s low.
- Latch byte (din[7] = 1):
  - index = din[6:4] ({ch[1:0], type}).
  - type 0, ch 0..2: tone[ch][3:0] = din[3:0].
  - type 1: vol[ch] = din[3:0].
  - ch 3, type 0: ctrl3 = din[2:0] and clr pulses.
- Data byte (din[7] = 0), applied to the latched index:
  - Tone index: tone[ch][9:4] = din[5:0].
  - Volume index: vol[ch] = din[3:0].
  - Noise index: ctrl3 = din[2:0] and clr pulses.
- clr is high for exactly one clk cycle, the same edge ctrl3 updates. It is not gated by clken.
- FSM states:
  - IDLE: on a write event, decode and go to BUSY (feature on) or REL (feature off).
  - BUSY: ready = 0; counter loads BUSY_CYCLES−1 and decrements on clken; at 0 with clken, go to REL.
  - REL: ready = 1; wait for s2 = 1 (strobe released), then go to IDLE.
- Write events in BUSY are ignored: no register change, no clr, and the latched index is unchanged.
- A strobe held low through BUSY is not re-accepted; a new falling edge is required.
- Reset mid-BUSY aborts the write count and forces ready = 1 at once. Registers already written revert to reset values.
- clken stuck low holds BUSY indefinitely. This is legal.

Optional Feature:
- JT89_READY_EN defined: BUSY state used; ready falls on the edge after the write event and rises after BUSY_CYCLES clken pulses.
- Not defined: BUSY removed; ready is tied to 1; writes are never ignored; the FSM is IDLE/REL only.

Decomposition:
- Shared package jt89_pkg holds:
  - Register index constants: IDX_TONE0 = 3'd0, IDX_VOL0 = 3'd1, IDX_TONE1 = 3'd2, IDX_VOL1 = 3'd3, IDX_TONE2 = 3'd4, IDX_VOL2 = 3'd5, IDX_NOISE = 3'd6, IDX_VOL3 = 3'd7.
  - FSM state encoding.
  - Reset constants VOL_OFF = 4'hF and TONE_RST = 10'd0.
- One sub-module, jt89_wrsync: the 3-flop synchroniser plus falling-edge detect, output we_ev.
- The decode, FSM and register file stay in jt89_regs.

Test Plan:
1. Assert rst_n = 0 with random stimulus → all outputs at reset values immediately; ready = 1.
2. Write 0x8E, then 0x0F (feature off) → tone0 = 10'h0FE; tone1 and tone2 stay 0; no clr.
3. Write 0xE5 → ctrl3 = 3'b101; clr high exactly 1 clk. Then write data byte 0x02 → ctrl3 = 3'b010 and a second clr pulse.
4. Write 0x9A, then 0x03 → vol0 = 4'hA, then vol0 = 4'h3; tone0 low nibble unchanged.
5. JT89_READY_EN, clken every 4th clk, write 0xC7 → ready low for exactly 32 clken pulses (128 clk). A second strobe 0xDF during BUSY → vol2 remains 4'h7.
6. JT89_READY_EN, rst_n pulsed low 10 clken into BUSY → ready = 1 asynchronously; tone2 = 0; a following write is accepted normally.
